// File: rtl/ti_mem_fetch.sv
// rtl/ti_mem_fetch.sv - T&I fetch responder: splits a record fetch into tagged word reads and reassembles them
module ti_mem_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_BITS  = 32,
  parameter int MAX_WORDS  = 12,
  parameter int TAG_WIDTH  = $clog2(MAX_WORDS),
  parameter int SIZE_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [SIZE_WIDTH-1:0]         mem_size,
  output logic [MAX_WORDS*WORD_BITS-1:0] mem_data,
  output logic                          valid_out,
  output logic                          ready_out,
  output logic                          mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [TAG_WIDTH-1:0]          mem_req_tag,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [WORD_BITS-1:0]          mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]          mem_rsp_tag,
  output logic                          mem_rsp_ready
);

  localparam int CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int MASK_W = 1 << TAG_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    nwords;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    rcv_cnt;
  logic [MASK_W-1:0]   mask;
  logic [SIZE_WIDTH:0] size_words;
  logic [CNT_W-1:0]    start_words;
  logic [CNT_W-1:0]    rcv_next;
  logic                rsp_hit;
  logic                req_fire;
  logic                last_issue;

  assign mem_rsp_ready = 1'b1;
  assign mem_req_tag   = TAG_WIDTH'(issue_cnt);

  assign size_words  = ({1'b0, mem_size} + (SIZE_WIDTH+1)'(3)) >> 2;
  assign start_words = (size_words > (SIZE_WIDTH+1)'(MAX_WORDS)) ? CNT_W'(MAX_WORDS)
                                                                : CNT_W'(size_words);

  // Only fresh, in-range tags count; duplicates and strays are dropped silently.
  assign rsp_hit    = mem_rsp_valid && (state == REQ || state == WAIT) &&
                      (CNT_W'(mem_rsp_tag) < nwords) && !mask[mem_rsp_tag];
  assign rcv_next   = rcv_cnt + CNT_W'(rsp_hit);
  assign req_fire   = mem_req_valid && mem_req_ready;
  assign last_issue = (issue_cnt + CNT_W'(1)) == nwords;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ready_out     <= 1'b1;
      valid_out     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_data      <= '0;
      nwords        <= '0;
      issue_cnt     <= '0;
      rcv_cnt       <= '0;
      mask          <= '0;
    end else begin
      if (rsp_hit) begin
        mask[mem_rsp_tag] <= 1'b1;
        rcv_cnt           <= rcv_next;
        for (int i = 0; i < MAX_WORDS; i++) begin
          if (mem_rsp_tag == TAG_WIDTH'(i))
            mem_data[i*WORD_BITS +: WORD_BITS] <= mem_rsp_data;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            mem_req_addr <= mem_addr & ~ADDR_WIDTH'(3);
            nwords       <= start_words;
            mem_data     <= '0;
            mask         <= '0;
            issue_cnt    <= '0;
            rcv_cnt      <= '0;
            ready_out    <= 1'b0;
            if (start_words == '0) begin
              state     <= DONE;
              valid_out <= 1'b1;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (req_fire) begin
            issue_cnt    <= issue_cnt + CNT_W'(1);
            mem_req_addr <= mem_req_addr + ADDR_WIDTH'(4);
            if (last_issue) begin
              mem_req_valid <= 1'b0;
              // A combinational responder may complete the fetch on the last issue.
              if (rcv_next == nwords) begin
                state     <= DONE;
                valid_out <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (rcv_next == nwords) begin
            state     <= DONE;
            valid_out <= 1'b1;
          end
        end
        DONE: begin
          valid_out <= 1'b0;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ti_mem_fetch.sv
// tb/tb_ti_mem_fetch.sv - scoreboard bench for ti_mem_fetch
module tb_ti_mem_fetch;

  localparam int DW = 12 * 32;
  typedef logic [DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [6:0]    mem_size = '0;
  logic [DW-1:0] mem_data;
  logic          valid_out;
  logic          ready_out;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic [3:0]    mem_req_tag;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_data = '0;
  logic [3:0]    mem_rsp_tag = '0;
  logic          mem_rsp_ready;

  ti_mem_fetch dut (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_data(mem_data), .valid_out(valid_out), .ready_out(ready_out),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int c0 = 0;
  int nvalid = 0;
  int last_valid_cyc = -1;

  word_t       exp_q[$];
  logic [31:0] rq_addr[$];
  logic [3:0]  rq_tag[$];
  int          rq_cyc[$];

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      rq_addr.push_back(mem_req_addr);
      rq_tag.push_back(mem_req_tag);
      rq_cyc.push_back(cyc);
    end
    if (valid_out) begin
      nvalid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_valid", word_t'(1), word_t'(0));
      else check("mem_data", mem_data, exp_q.pop_front());
    end
  end

  function automatic word_t seq_words(input int n, input logic [31:0] base);
    word_t r = '0;
    for (int i = 0; i < n; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [6:0] s);
    mem_addr = a;
    mem_size = s;
    start = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic respond_inorder(input int ncyc, input logic [31:0] base);
    for (int i = 0; i < ncyc; i++) begin
      mem_rsp_valid = mem_req_valid && mem_req_ready;
      mem_rsp_tag   = mem_req_tag;
      mem_rsp_data  = base + 32'(mem_req_tag);
      step();
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic check_reqs(input string name, input int n, input logic [31:0] base);
    check({name, "_req_count"}, word_t'(rq_addr.size()), word_t'(n));
    for (int k = 0; k < n && k < rq_addr.size(); k++) begin
      check({name, "_req_addr"}, word_t'(rq_addr[k]), word_t'(base + 32'(4 * k)));
      check({name, "_req_tag"}, word_t'(rq_tag[k]), word_t'(k));
    end
    rq_addr.delete();
    rq_tag.delete();
    rq_cyc.delete();
  endtask

  initial begin
    int nv0;
    int tcyc;
    logic [31:0] d2[12];
    logic [31:0] pa;
    logic [3:0]  pt;
    logic        pv;
    logic        pat[7];
    word_t       e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", word_t'(ready_out), word_t'(1));
    check("rst_valid", word_t'(valid_out), word_t'(0));
    check("rst_req_valid", word_t'(mem_req_valid), word_t'(0));
    check("rst_data", mem_data, '0);
    check("rst_rsp_ready", word_t'(mem_rsp_ready), word_t'(1));
    reset = 1'b0;
    step();

    // 32-byte in-order zero-latency fetch
    mem_req_ready = 1'b1;
    nv0 = nvalid;
    exp_q.push_back(seq_words(8, 32'hA0));
    do_start(32'h1000, 7'd32);
    check("t1_ready_low", word_t'(ready_out), word_t'(0));
    check("t1_req_valid", word_t'(mem_req_valid), word_t'(1));
    respond_inorder(12, 32'hA0);
    for (int k = 0; k < 8 && k < rq_cyc.size(); k++)
      check("t1_req_cyc", word_t'(rq_cyc[k]), word_t'(c0 + 1 + k));
    check_reqs("t1", 8, 32'h1000);
    check("t1_valid_count", word_t'(nvalid - nv0), word_t'(1));
    check("t1_valid_cyc", word_t'(last_valid_cyc), word_t'(c0 + 9));
    check("t1_ready_back", word_t'(ready_out), word_t'(1));

    // 48-byte fetch, reverse-order responses with gaps
    nv0 = nvalid;
    e = '0;
    for (int i = 0; i < 12; i++) begin
      d2[i] = $urandom;
      e[i*32 +: 32] = d2[i];
    end
    exp_q.push_back(e);
    do_start(32'h2000, 7'd48);
    repeat (12) step();
    tcyc = 0;
    for (int t = 11; t >= 0; t--) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 4'(t);
      mem_rsp_data  = d2[t];
      tcyc = cyc;
      step();
      mem_rsp_valid = 1'b0;
      repeat (3) step();
    end
    check_reqs("t2", 12, 32'h2000);
    check("t2_valid_count", word_t'(nvalid - nv0), word_t'(1));
    check("t2_valid_cyc", word_t'(last_valid_cyc), word_t'(tcyc + 1));

    // 16-byte fetch with request back-pressure
    nv0 = nvalid;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_q.push_back(seq_words(4, 32'h50));
    do_start(32'h4000, 7'd16);
    for (int i = 0; i < 7; i++) begin
      mem_req_ready = pat[i];
      pa = mem_req_addr;
      pt = mem_req_tag;
      pv = mem_req_valid;
      step();
      if (!pat[i] && pv) begin
        check("t3_stall_addr", word_t'(mem_req_addr), word_t'(pa));
        check("t3_stall_tag", word_t'(mem_req_tag), word_t'(pt));
      end
    end
    mem_req_ready = 1'b0;
    step();
    check_reqs("t3", 4, 32'h4000);
    mem_req_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 4'(t);
      mem_rsp_data  = 32'h50 + 32'(t);
      step();
    end
    mem_rsp_valid = 1'b0;
    repeat (3) step();
    check("t3_valid_count", word_t'(nvalid - nv0), word_t'(1));
    check("t3_no_more_req", word_t'(rq_addr.size()), word_t'(0));

    // unaligned odd size, then zero size
    nv0 = nvalid;
    exp_q.push_back(seq_words(2, 32'hC0));
    do_start(32'h3003, 7'd5);
    respond_inorder(5, 32'hC0);
    check_reqs("t4", 2, 32'h3000);
    exp_q.push_back('0);
    do_start(32'h5000, 7'd0);
    check("t4_zero_valid", word_t'(valid_out), word_t'(1));
    check("t4_zero_req_valid", word_t'(mem_req_valid), word_t'(0));
    step();
    check("t4_zero_ready", word_t'(ready_out), word_t'(1));
    check("t4_zero_valid_low", word_t'(valid_out), word_t'(0));
    step();
    check_reqs("t4z", 0, 32'h0);
    check("t4_valid_count", word_t'(nvalid - nv0), word_t'(2));

    // ignored start while busy, duplicate and out-of-range responses
    nv0 = nvalid;
    e = '0;
    e[31:0]  = 32'h1111_0000;
    e[63:32] = 32'h2222_0001;
    e[95:64] = 32'h3333_0002;
    exp_q.push_back(e);
    do_start(32'h6000, 7'd12);
    mem_addr = 32'h7000;
    mem_size = 7'd48;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = 4'd1; mem_rsp_data = 32'h2222_0001; step();
    mem_rsp_tag = 4'd1; mem_rsp_data = 32'hDEAD_BEEF; step();
    mem_rsp_tag = 4'd5; mem_rsp_data = 32'hBAD0_0005; step();
    mem_rsp_tag = 4'd0; mem_rsp_data = 32'h1111_0000; step();
    mem_rsp_tag = 4'd2; mem_rsp_data = 32'h3333_0002; step();
    mem_rsp_valid = 1'b0;
    repeat (4) step();
    check("t5_idle_req_valid", word_t'(mem_req_valid), word_t'(0));
    check_reqs("t5", 3, 32'h6000);
    check("t5_valid_count", word_t'(nvalid - nv0), word_t'(1));

    // asynchronous reset in WAIT, late response, then clean fetch
    nv0 = nvalid;
    do_start(32'h8000, 7'd16);
    repeat (4) step();
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = 4'd0; mem_rsp_data = 32'h8800_0000; step();
    mem_rsp_tag = 4'd1; mem_rsp_data = 32'h8800_0001; step();
    mem_rsp_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("t6_rst_ready", word_t'(ready_out), word_t'(1));
    check("t6_rst_valid", word_t'(valid_out), word_t'(0));
    check("t6_rst_req_valid", word_t'(mem_req_valid), word_t'(0));
    check("t6_rst_data", mem_data, '0);
    #2 reset = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = 4'd2; mem_rsp_data = 32'h8800_0002;
    step();
    mem_rsp_valid = 1'b0;
    step();
    check("t6_late_rsp_data", mem_data, '0);
    check("t6_no_valid", word_t'(nvalid - nv0), word_t'(0));
    rq_addr.delete();
    rq_tag.delete();
    rq_cyc.delete();
    exp_q.push_back(seq_words(2, 32'hD0));
    do_start(32'h9000, 7'd8);
    respond_inorder(6, 32'hD0);
    check_reqs("t6", 2, 32'h9000);
    check("t6_valid_count", word_t'(nvalid - nv0), word_t'(1));

    check("sb_drained", word_t'(exp_q.size()), word_t'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
